fifo_read_serializer: RTL and testbench

Read-side consumer for the team's 16-bit FIFO datapath. It pops words through the FIFO's empty/read-enable interface and loads each word into a shift register. It then streams the word MSB-first as single bits to a downstream sink using a valid/ready handshake. It also counts words drained and flags first and last bit of each word.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/piso_shreg.sv | 41 ++++
 rtl/fifo_read_serializer.sv | 111 +++++++++++
 tb/tb_fifo_read_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the 16-bit FIFO read-side datapath.
//   W_DEF   : default data word width
//   CW_DEF  : default width of the delivered-word counter
//   state_t : FSM state encoding for fifo_read_serializer
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage : fifo_pkg

// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
// W-bit parallel-load, left-shift register with zero fill. Load has priority
// over shift.
//   clk : system clock
//   rst : synchronous reset, active-low
//   ld  : load d into the register
//   sh  : shift left by one, LSB filled with 0
//   d   : parallel load data
//   msb : register bit W-1
// ---------------------------------------------------------------------------
module piso_shreg
  import fifo_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] r_shreg;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg <= '0;
    end else if (ld) begin
      r_shreg <= d;
    end else if (sh) begin
      r_shreg <= {r_shreg[W-2:0], 1'b0};
    end
  end

  assign msb = r_shreg[W-1];

endmodule : piso_shreg

// File: rtl/fifo_read_serializer.sv
// ---------------------------------------------------------------------------
// fifo_read_serializer
// Pops words from a FIFO (1-cycle read latency), then streams each word
// MSB-first as single bits over a valid/ready handshake. Counts delivered
// words and flags the first and last bit of each word.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   en         : drain enable, sampled only at pop decision points
//   fifo_empty : FIFO empty flag
//   fifo_rd    : FIFO read strobe, one cycle per word
//   fifo_rdata : FIFO read data, valid the cycle after fifo_rd
//   ser_out    : serial data bit (shift register MSB)
//   ser_valid  : ser_out holds a valid bit
//   ser_ready  : sink accepts the bit when ser_valid && ser_ready
//   bit_first  : current bit is bit W-1 of its word
//   bit_last   : current bit is bit 0 of its word
//   busy       : FSM not idle
//   word_cnt   : words fully delivered since reset, wraps
// ---------------------------------------------------------------------------
module fifo_read_serializer
  import fifo_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [W-1:0]  fifo_rdata,
  output logic          ser_out,
  output logic          ser_valid,
  input  logic          ser_ready,
  output logic          bit_first,
  output logic          bit_last,
  output logic          busy,
  output logic [CW-1:0] word_cnt
);

  localparam int            BW       = $clog2(W);
  localparam logic [BW-1:0] LAST_IDX = BW'(W - 1);

  state_t         r_state;
  logic [BW-1:0]  r_bit_cnt;
  logic [CW-1:0]  r_word_cnt;

  logic w_in_shift;
  logic w_hs;
  logic w_last_hs;
  logic w_can_pop;
  logic w_ld;
  logic w_sh;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_hs       = w_in_shift && ser_ready;
  assign w_last_hs  = w_hs && (r_bit_cnt == '0);
  assign w_can_pop  = en && !fifo_empty;

  // fifo_rd is combinational so a pop can be issued on the last-bit
  // handshake itself. It is gated by rst: the FIFO must not lose a word to a
  // pop that the FSM will ignore because reset wins that edge.
  assign fifo_rd = rst && w_can_pop && ((r_state == ST_IDLE) || w_last_hs);

  assign w_ld = (r_state == ST_WAIT);
  assign w_sh = w_hs && (r_bit_cnt != '0);

  piso_shreg #(.W(W)) u_shreg (
    .clk (clk),
    .rst (rst),
    .ld  (w_ld),
    .sh  (w_sh),
    .d   (fifo_rdata),
    .msb (ser_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (fifo_rd) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_bit_cnt <= LAST_IDX;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last_hs) begin
            r_word_cnt <= r_word_cnt + CW'(1);
            r_state    <= fifo_rd ? ST_WAIT : ST_IDLE;
          end else if (w_hs) begin
            r_bit_cnt <= r_bit_cnt - BW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flags are decoded from registers only; ser_ready never reaches ser_valid.
  assign ser_valid = w_in_shift;
  assign bit_first = w_in_shift && (r_bit_cnt == LAST_IDX);
  assign bit_last  = w_in_shift && (r_bit_cnt == '0);
  assign busy      = (r_state != ST_IDLE);
  assign word_cnt  = r_word_cnt;

endmodule : fifo_read_serializer

// File: tb/tb_fifo_read_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_serializer
// Directed bench: a memory-backed FIFO model feeds the DUT; every word pushed
// also pushes its 16 expected bits (with first/last flags) to a scoreboard
// that a negedge monitor pops on each accepted handshake.
// ---------------------------------------------------------------------------
module tb_fifo_read_serializer;

  localparam int W  = 16;
  localparam int CW = 8;
  localparam int DEPTH = 1024;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [W-1:0]  fifo_rdata;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready;
  logic          bit_first;
  logic          bit_last;
  logic          busy;
  logic [CW-1:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  exp_t         exp_q[$];
  logic [W-1:0] mem [DEPTH];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           hs_count  = 0;
  int           rd_pulses = 0;
  int           exp_words = 0;

  fifo_read_serializer #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .bit_first  (bit_first),
    .bit_last   (bit_last),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model with exactly one cycle of read latency.
  assign fifo_empty = (wr_ptr == rd_ptr);
  initial fifo_rdata = '0;
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      fifo_rdata <= mem[rd_ptr % DEPTH];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    mem[wr_ptr % DEPTH] = w;
    wr_ptr = wr_ptr + 1;
    for (int i = W - 1; i >= 0; i--) begin
      e.b     = w[i];
      e.first = (i == W - 1);
      e.last  = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && hs_count < target; i++) tick();
    check(tag, {31'd0, hs_count >= target}, 32'd1);
  endtask

  // Monitor: scoreboard compare on handshakes, hold stability under
  // backpressure, and fifo_rd never issued against an empty FIFO.
  logic have_prev = 1'b0;
  logic prev_out, prev_first, prev_last;
  always @(negedge clk) begin
    if (rst === 1'b1 && ser_valid === 1'b1) begin
      if (have_prev) begin
        check("hold_ser_out", {31'd0, ser_out},   {31'd0, prev_out});
        check("hold_first",   {31'd0, bit_first}, {31'd0, prev_first});
        check("hold_last",    {31'd0, bit_last},  {31'd0, prev_last});
      end
      if (ser_ready === 1'b1) begin
        have_prev = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ser_out",   {31'd0, ser_out},   {31'd0, e.b});
          check("bit_first", {31'd0, bit_first}, {31'd0, e.first});
          check("bit_last",  {31'd0, bit_last},  {31'd0, e.last});
        end
        hs_count++;
      end else begin
        have_prev  = 1'b1;
        prev_out   = ser_out;
        prev_first = bit_first;
        prev_last  = bit_last;
      end
    end else begin
      have_prev = 1'b0;
    end
    if (fifo_rd === 1'b1) begin
      rd_pulses++;
      check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
  end

  initial begin
    int hs0, rd0, n;
    logic [3:0] pat;

    // --- reset held with en=1 and a word waiting ---
    rst       = 1'b0;
    en        = 1'b1;
    ser_ready = 1'b1;
    push_word(16'hA5C3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_fifo_rd",   {31'd0, fifo_rd},   32'd0);
      check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
      check("rst_word_cnt",  {24'd0, word_cnt},  32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_ser_out",   {31'd0, ser_out},   32'd0);
      check("rst_flags",     {30'd0, bit_first, bit_last}, 32'd0);
    end

    // --- single word A5C3: rd, WAIT, then first valid bit ---
    rst = 1'b1;
    #1;
    check("first_fifo_rd", {31'd0, fifo_rd}, 32'd1);
    tick();
    check("wait_valid", {31'd0, ser_valid}, 32'd0);
    check("wait_rd",    {31'd0, fifo_rd},   32'd0);
    check("wait_busy",  {31'd0, busy},      32'd1);
    tick();
    check("latency_valid", {31'd0, ser_valid}, 32'd1);
    wait_idle("single_idle", 40);
    exp_words = 1;
    check("single_word_cnt", {24'd0, word_cnt}, exp_words);
    check("single_drained", exp_q.size(), 32'd0);

    // --- backpressure with ready pattern 1,0,0,1 ---
    hs0 = hs_count;
    pat = 4'b1001;
    push_word(16'h8001);
    for (int c = 0; c < 80; c++) begin
      ser_ready = pat[c % 4];
      tick();
    end
    ser_ready = 1'b1;
    wait_idle("bp_idle", 10);
    check("bp_handshakes", hs_count - hs0, 32'd16);
    exp_words++;
    check("bp_word_cnt", {24'd0, word_cnt}, exp_words);

    // --- back-to-back FFFF then 0000 ---
    push_word(16'hFFFF);
    push_word(16'h0000);
    tick();
    tick();
    check("b2b_first", {31'd0, bit_first}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("b2b_last1",     {31'd0, bit_last}, 32'd1);
    check("b2b_prefetch",  {31'd0, fifo_rd},  32'd1);
    tick();
    check("b2b_bubble",    {31'd0, ser_valid}, 32'd0);
    check("b2b_busy",      {31'd0, busy},      32'd1);
    tick();
    check("b2b_resume",    {31'd0, bit_first}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("b2b_last2",     {31'd0, bit_last}, 32'd1);
    check("b2b_no_rd",     {31'd0, fifo_rd},  32'd0);
    tick();
    check("b2b_idle",      {31'd0, busy}, 32'd0);
    exp_words += 2;
    check("b2b_word_cnt",  {24'd0, word_cnt}, exp_words);

    // --- empty FIFO: no pop ---
    rd0 = rd_pulses;
    for (int i = 0; i < 20; i++) tick();
    check("empty_no_rd",   rd_pulses - rd0, 32'd0);
    check("empty_idle",    {31'd0, busy}, 32'd0);

    // --- en dropped at bit 5: word completes, second word stays queued ---
    rd0 = rd_pulses;
    hs0 = hs_count;
    push_word(16'h1234);
    push_word(16'h5678);
    wait_hs("en_reach_bit5", hs0 + 5, 30);
    en = 1'b0;
    wait_idle("en_idle", 40);
    for (int i = 0; i < 10; i++) tick();
    check("en_one_pop",    rd_pulses - rd0, 32'd1);
    check("en_still_idle", {31'd0, busy}, 32'd0);
    check("en_fifo_left",  {31'd0, fifo_empty}, 32'd0);
    check("en_pending",    exp_q.size(), 32'd16);
    exp_words++;
    check("en_word_cnt",   {24'd0, word_cnt}, exp_words);
    en = 1'b1;
    tick();
    wait_idle("en_resume_idle", 40);
    exp_words++;
    check("en_resume_cnt", {24'd0, word_cnt}, exp_words);

    // --- counter wrap: deliver enough words to land on 0 ---
    n = 256 - (exp_words % 256);
    for (int i = 0; i < n; i++) push_word(W'($urandom));
    tick();
    wait_idle("wrap_idle", n * 18 + 20);
    exp_words += n;
    check("wrap_word_cnt", {24'd0, word_cnt}, exp_words % 256);
    check("wrap_drained",  exp_q.size(), 32'd0);

    // --- reset mid-word at bit 7 ---
    hs0 = hs_count;
    push_word(16'hC3A5);
    tick();
    wait_hs("mid_reach_bit7", hs0 + 7, 30);
    push_word(16'h0F0F); // queued, must not be popped during reset
    rd0 = rd_pulses;
    rst = 1'b0;
    tick();
    check("mid_valid",    {31'd0, ser_valid}, 32'd0);
    check("mid_ser_out",  {31'd0, ser_out},   32'd0);
    check("mid_flags",    {30'd0, bit_first, bit_last}, 32'd0);
    check("mid_busy",     {31'd0, busy},      32'd0);
    check("mid_fifo_rd",  {31'd0, fifo_rd},   32'd0);
    check("mid_word_cnt", {24'd0, word_cnt},  32'd0);
    check("mid_no_pop",   rd_pulses - rd0,    32'd0);
    // Drop the discarded word's remaining bits; the queued word follows.
    for (int i = 0; i < W - 7; i++) void'(exp_q.pop_front());
    rst = 1'b1;
    tick();
    wait_idle("mid_recover_idle", 40);
    check("mid_recover_cnt", {24'd0, word_cnt}, 32'd1);
    check("mid_drained",     exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_read_serializer
